// File: rtl/pipe_mem_arbiter.sv
// pipe_mem_arbiter: serialises IF fetches and MEM loads/stores onto one fixed-latency memory port, data first.
// Define PIPE_ARB_STATS_EN to build the stall/conflict cycle counters; otherwise they read 0.
module pipe_mem_arbiter #(
    parameter int MEM_LAT = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ireq,
    input  logic [31:0] iaddr,
    input  logic        mm2reg,
    input  logic        mwmem,
    input  logic [31:0] malu,
    input  logic [31:0] mb,
    output logic [31:0] irdata,
    output logic [31:0] drdata,
    output logic        stall,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [31:0] stall_cycles,
    output logic [31:0] conflict_cycles
);
    typedef enum logic [1:0] {IDLE, DACC, IACC} state_t;
    state_t state;
    logic [3:0] cnt;
    logic ihave, dhave;
    logic dpend, ipend, last, dcomp, icomp, arb, dneed, ineed;
    assign dpend = mm2reg | mwmem;
    assign ipend = ireq;
    assign stall = (dpend & ~dhave) | (ipend & ~ihave);
    assign last  = (state != IDLE) && (cnt == 4'd0);
    assign dcomp = last && (state == DACC);
    assign icomp = last && (state == IACC);
    assign arb   = (state == IDLE) || last;
    // the access finishing this cycle must not be reissued
    assign dneed = dpend & ~dhave & ~dcomp;
    assign ineed = ipend & ~ihave & ~icomp;
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            ihave     <= 1'b0;
            dhave     <= 1'b0;
            irdata    <= 32'd0;
            drdata    <= 32'd0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
        end else begin
            if (arb) begin
                state  <= dneed ? DACC : ineed ? IACC : IDLE;
                cnt    <= (dneed | ineed) ? 4'(MEM_LAT - 1) : 4'd0;
                mem_en <= dneed | ineed;
                mem_we <= dneed & mwmem & ~mm2reg;
                if (dneed) begin
                    mem_addr  <= malu;
                    mem_wdata <= mb;
                end else if (ineed) begin
                    mem_addr  <= iaddr;
                    mem_wdata <= 32'd0;
                end
            end else begin
                cnt <= cnt - 4'd1;
            end
            // a request flushed mid-access has its result dropped
            if (dcomp && !mem_we && dpend)
                drdata <= mem_rdata;
            if (icomp && ipend)
                irdata <= mem_rdata;
            ihave <= stall & (ihave | (icomp & ipend));
            dhave <= stall & (dhave | (dcomp & dpend));
        end
    end
`ifdef PIPE_ARB_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cycles    <= 32'd0;
            conflict_cycles <= 32'd0;
        end else begin
            if (stall)
                stall_cycles <= stall_cycles + 32'd1;
            if (arb && dneed && ineed)
                conflict_cycles <= conflict_cycles + 32'd1;
        end
    end
`else
    assign stall_cycles    = 32'd0;
    assign conflict_cycles = 32'd0;
`endif
endmodule

// File: doc/pipe_mem_arbiter.md
# pipe_mem_arbiter

Sequencer for the single-port instruction/data memory shared by the IF and MEM stages of the 5-stage pipeline. Accepts a fetch request from IF and a load/store request from the EX/MEM register outputs (`mm2reg`, `mwmem`, `malu`, `mb`). Serialises them onto one fixed-latency memory port, data first. Drives one global `stall` that freezes the PC and every pipeline register until both requests of the current cycle are satisfied.

## Interface
Parameters:
- `MEM_LAT`, 2: memory access latency in cycles, legal range 1..15.

Ports:
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `ireq` in 1: fetch request from IF, held while `stall`.
- `iaddr` in 32: fetch byte address, stable while `stall`.
- `mm2reg` in 1: load in MEM stage.
- `mwmem` in 1: store in MEM stage.
- `malu` in 32: data byte address.
- `mb` in 32: store data.
- `irdata` out 32: fetched instruction, registered.
- `drdata` out 32: load data, registered.
- `stall` out 1: freeze pipeline (combinational from registered state and inputs).
- `mem_en` out 1: memory access active.
- `mem_we` out 1: memory write.
- `mem_addr` out 32: memory address.
- `mem_wdata` out 32: memory write data.
- `mem_rdata` in 32: memory read data, valid on the last access cycle.
- `stall_cycles` out 32: count of cycles with `stall`=1.
- `conflict_cycles` out 32: count of cycles in which both `ipend` and `dpend` were unserved.

## Operation
- Definitions: `dpend` = `mm2reg` | `mwmem`; `ipend` = `ireq`. Both `mm2reg` and `mwmem` high means load.
- `ihave` and `dhave` flags are set when the corresponding access completes.
- `stall` = (`dpend` & ~`dhave`) | (`ipend` & ~`ihave`).
- Both flags clear on any cycle with `stall`=0, when the pipeline advances.
- States:
  - `IDLE`: no access.
  - `DACC`: data access; counter loaded with MEM_LAT-1, decrements each cycle.
  - `IACC`: fetch access; counter loaded with MEM_LAT-1, decrements each cycle.
- Arbitration, evaluated in `IDLE` and on the last cycle of `DACC`/`IACC`:
  - If `dpend` & ~`dhave` & not the access just completing, go to `DACC`.
  - Else if `ipend` & ~`ihave` & not the access just completing, go to `IACC`.
  - Else go to `IDLE`.
  - Back-to-back accesses therefore have no bubble.
- On entry to `DACC`/`IACC`, the address, write enable and write data are latched into `mem_addr`, `mem_we`, `mem_wdata`. These stay constant for MEM_LAT cycles with `mem_en`=1.
  - `mem_we` = `mwmem` & ~`mm2reg`, in `DACC` only.
  - `mem_we` = 0 in `IACC`.
- On the last access cycle (counter = 0):
  - Load: `drdata` <= `mem_rdata`.
  - Fetch: `irdata` <= `mem_rdata`.
  - Store: `drdata` unchanged.
  - The corresponding have-flag is set.
- `irdata` and `drdata` hold their values until the next completion of the same kind.

## Timing
- Reset values: state `IDLE`; counter 0; `ihave`=`dhave`=0; `irdata`, `drdata`, `mem_addr`, `mem_wdata` = 0; `mem_en`=`mem_we`=0; stats counters 0.
- Lone request first seen in `IDLE` at cycle t:
  - `mem_en`=1 during cycles t+1..t+MEM_LAT.
  - Result and have-flag are valid at t+MEM_LAT+1.
  - `stall`=1 during t..t+MEM_LAT, i.e. MEM_LAT+1 stall cycles.
- Simultaneous fetch and data request at cycle t:
  - `DACC` runs t+1..t+MEM_LAT; `IACC` runs t+MEM_LAT+1..t+2·MEM_LAT.
  - `stall` falls at t+2·MEM_LAT+1.
- A request that drops while its access is in flight, which only happens on a flush: the access completes, its result is discarded, and no extra stall occurs.
- Reset mid-access: the next cycle is `IDLE` with `mem_en`=0. The partial access is abandoned, and a store in flight may or may not have been written.
- Stats counters wrap modulo 2^32.

## Configuration
- `PIPE_ARB_STATS_EN`:
  - Defined: `stall_cycles` and `conflict_cycles` increment as specified.
  - Undefined: counter logic is removed and both outputs are tied to 0.
  - Ports are present in both cases.

## Test plan
- MEM_LAT=2, `ireq`=1, `iaddr`=0x40, memory returns 0x8C220004 → `stall`=1 for exactly 3 cycles, `mem_en` high 2 cycles with `mem_addr`=0x40, `irdata`=0x8C220004 when `stall` falls.
- Simultaneous `ireq` (0x44) and load `malu`=0x100, memory returns 0x1234 → data access first, fetch immediately after with no idle cycle, `drdata`=0x1234, 5 stall cycles.
- Store `malu`=0x200, `mb`=0xDEADBEEF with no fetch → `mem_we`=1, `mem_wdata`=0xDEADBEEF for 2 cycles, `drdata` unchanged, 3 stall cycles.
- Fetch and store with `ihave` set from the previous cycle's completion and the pipeline still stalled → no second fetch issued, `ihave` holds until `stall`=0.
- `reset` asserted on the 2nd cycle of `DACC` → next cycle `mem_en`=0, `stall` re-evaluated from cleared flags, `drdata`=0.
- With `PIPE_ARB_STATS_EN` defined, run the simultaneous-request scenario → `stall_cycles`=5, `conflict_cycles`=1. Without the macro, both read 0.
